boot_ctrl: RTL

//  Parametrised warmboot request controller; replaces the fixed USB-detect/μACM boot latch in the top level.

---
 rtl/boot_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/boot_ctrl.sv
// boot_ctrl: warmboot request controller arbitrating button, USB-detect and ACM boot sources (option: BOOT_CTRL_SEL_TIMEOUT_EN)
module boot_ctrl #(
  parameter int CLK_HZ         = 48_000_000,
  parameter int N_IMAGES       = 4,
  parameter int DEFAULT_IMAGE  = 1,
  parameter int DEBOUNCE_US    = 10_000,
  parameter int LONG_PRESS_MS  = 1_000,
  parameter int USB_STABLE_MS  = 100,
  parameter int SEL_TIMEOUT_MS = 5_000,
  localparam int IW = $clog2(N_IMAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_n,
  input  logic          usb_dp,
  input  logic          usb_dn,
  input  logic          acm_boot,
  output logic          boot,
  output logic [IW-1:0] image,
  output logic [IW-1:0] sel,
  output logic          led
);
  localparam int DB   = CLK_HZ / 1_000_000 * DEBOUNCE_US;
  localparam int LONG = CLK_HZ / 1_000 * LONG_PRESS_MS;
  localparam int US   = CLK_HZ / 1_000 * USB_STABLE_MS;
  localparam int DBW  = $clog2(DB + 1);
  localparam int LW   = $clog2(LONG + 1);
  localparam int UW   = $clog2(US + 1);
  localparam logic [IW-1:0] DEF = IW'(DEFAULT_IMAGE);

  typedef enum logic [1:0] {IDLE, PRESSED, COMMIT} state_t;

  state_t state, state_nxt;
  logic [1:0] btn_sync, dp_sync, dn_sync;
  logic [DBW-1:0] db_cnt;
  logic [LW-1:0] hold_cnt;
  logic [UW-1:0] usb_cnt;
  logic b, usb_req, usb_low, btn_raw, boot_req, long_done, commit, adv, timeout, boot_nxt;
  logic [IW-1:0] image_nxt, sel_nxt;

  assign btn_raw   = ~btn_sync[1];
  assign usb_low   = ~dp_sync[1] & ~dn_sync[1];
  assign boot_req  = usb_req | acm_boot;
  assign long_done = b && hold_cnt == LW'(LONG - 1);

  // Two-flop synchronisers; idle levels (released, pulled up) on reset
  always_ff @(posedge clk) begin
    btn_sync <= rst ? 2'b11 : {btn_sync[0], btn_n};
    dp_sync  <= rst ? 2'b11 : {dp_sync[0], usb_dp};
    dn_sync  <= rst ? 2'b11 : {dn_sync[0], usb_dn};
  end

  // Button debounce: accept a new level after it differs for DB consecutive cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      b      <= 1'b0;
    end else if (btn_raw == b) begin
      db_cnt <= '0;
    end else if (db_cnt == DBW'(DB - 1)) begin
      db_cnt <= '0;
      b      <= btn_raw;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // USB cable detect on raw synchronised lines; request is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      usb_cnt <= '0;
      usb_req <= 1'b0;
    end else begin
      usb_cnt <= !usb_low ? '0 : usb_cnt == UW'(US) ? usb_cnt : usb_cnt + 1'b1;
      usb_req <= usb_req | (usb_low && usb_cnt == UW'(US - 1));
    end
  end

  // Hold counter runs only while pressed, saturating at the long-press threshold
  always_ff @(posedge clk) begin
    if (rst || state != PRESSED) hold_cnt <= '0;
    else if (hold_cnt != LW'(LONG)) hold_cnt <= hold_cnt + 1'b1;
  end

`ifdef BOOT_CTRL_SEL_TIMEOUT_EN
  localparam int SEL_TO = CLK_HZ / 1_000 * SEL_TIMEOUT_MS;
  localparam int TW     = $clog2(SEL_TO + 1);
  logic [TW-1:0] idle_cnt;
  logic idle_run;
  assign idle_run = state == IDLE && !b && !boot_req && sel != DEF;
  assign timeout  = idle_run && idle_cnt == TW'(SEL_TO - 1);
  // Idle counter returns the selection to the default image after inactivity
  always_ff @(posedge clk) begin
    if (rst || !idle_run || timeout) idle_cnt <= '0;
    else idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      boot  <= 1'b0;
      image <= DEF;
      sel   <= DEF;
    end else begin
      state <= state_nxt;
      boot  <= boot_nxt;
      image <= image_nxt;
      sel   <= sel_nxt;
    end
  end

  // Next state: bootloader requests preempt everything, COMMIT is terminal
  always_comb begin
    state_nxt = state == COMMIT ? COMMIT :
                boot_req        ? COMMIT :
                state == IDLE   ? (b ? PRESSED : IDLE) :
                !b              ? IDLE :
                long_done       ? COMMIT : PRESSED;
  end

  // Outputs: commit latches image once; short release advances selection skipping image 0
  always_comb begin
    led       = state != IDLE;
    commit    = state != COMMIT && state_nxt == COMMIT;
    boot_nxt  = boot | commit;
    image_nxt = commit ? (boot_req ? '0 : sel) : image;
    adv       = state == PRESSED && !b && !boot_req;
    sel_nxt   = adv ? (sel == IW'(N_IMAGES - 1) ? IW'(1) : sel + IW'(1)) : timeout ? DEF : sel;
  end
endmodule
